// File: rtl/alu_issue_arbiter_if.sv
// Request/response bundle between the two ALU requesters and the issue arbiter.
// The requester side is the master; the arbiter is the slave.
interface alu_issue_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;
  logic              req0_setf;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;

  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_ready;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_setf,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_setf,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Shares one combinational ALU between the execute stage (port 0) and the PC unit (port 1),
// buffers one result and owns the NZCV flag register whose C bit feeds the ALU carry-in.
module alu_issue_arbiter #(
  parameter int DATA_W     = 32,
  parameter int OP_W       = 5,
  parameter bit RR_MODE    = 1'b1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_issue_arbiter_if.slave  bus,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_op,
  output logic                alu_cin,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic                alu_c,
  input  logic                alu_v,
  output logic [3:0]          flags_q
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]        state_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              last_q;
  logic [SW-1:0]     starve_cnt;

  logic can_issue;
  logic grant0;
  logic grant1;
  logic drain;
  logic starve_hit;

  // Ready is forced low while reset is held, even though the state already reads EMPTY.
  assign can_issue  = rst_n && ((state_q == EMPTY) || bus.rsp_ready);
  assign drain      = (state_q == FULL) && bus.rsp_ready;
  assign starve_hit = (starve_cnt == STARVE_LIMIT);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (can_issue) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (RR_MODE) begin
          grant0 = last_q;
          grant1 = !last_q;
        end else begin
          grant0 = !starve_hit;
          grant1 = starve_hit;
        end
      end else if (bus.req0_valid) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  assign alu_a   = grant1 ? bus.req1_a  : bus.req0_a;
  assign alu_b   = grant1 ? bus.req1_b  : bus.req0_b;
  assign alu_op  = grant1 ? bus.req1_op : bus.req0_op;
  assign alu_cin = flags_q[1];

  assign bus.rsp_valid = (state_q == FULL);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

  // A new issue wins over a drain on the same edge, keeping the buffer full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
    end else if (grant0 || grant1) begin
      state_q    <= FULL;
      rsp_id_q   <= grant1;
      rsp_data_q <= alu_out;
    end else if (drain) begin
      state_q    <= EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (grant0 && bus.req0_setf) begin
      flags_q <= {alu_out[DATA_W-1], (alu_out == '0), alu_c, alu_v};
    end
  end

  // last_q=1 means port 1 was granted last, so port 0 wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (grant0) begin
      last_q <= 1'b0;
    end else if (grant1) begin
      last_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant1) begin
      starve_cnt <= '0;
    end else if (bus.req1_valid && can_issue && !starve_hit) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  a_one_ready : assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.req0_ready && bus.req1_ready));

  a_starve_bound : assert property (@(posedge clk) disable iff (!rst_n)
    starve_cnt <= STARVE_LIMIT);

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with identical stimulus and checks
// both against a cycle-level reference model plus a table of hand-computed vectors.
module tb_alu_issue_arbiter;

  localparam int DW     = 32;
  localparam int OW     = 5;
  localparam int STARVE = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // shared stimulus
  logic          s_v0, s_setf0, s_v1, s_rdy;
  logic [DW-1:0] s_a0, s_b0, s_a1, s_b1;
  logic [OW-1:0] s_op0, s_op1;

  alu_issue_arbiter_if #(.DATA_W(DW), .OP_W(OW)) bus_rr ();
  alu_issue_arbiter_if #(.DATA_W(DW), .OP_W(OW)) bus_fp ();

  logic [DW-1:0] rr_a, rr_b, rr_out, fp_a, fp_b, fp_out;
  logic [OW-1:0] rr_op, fp_op;
  logic          rr_cin, rr_c, rr_v, fp_cin, fp_c, fp_v;
  logic [3:0]    rr_flags, fp_flags;

  assign bus_rr.req0_valid = s_v0;   assign bus_fp.req0_valid = s_v0;
  assign bus_rr.req0_a     = s_a0;   assign bus_fp.req0_a     = s_a0;
  assign bus_rr.req0_b     = s_b0;   assign bus_fp.req0_b     = s_b0;
  assign bus_rr.req0_op    = s_op0;  assign bus_fp.req0_op    = s_op0;
  assign bus_rr.req0_setf  = s_setf0; assign bus_fp.req0_setf = s_setf0;
  assign bus_rr.req1_valid = s_v1;   assign bus_fp.req1_valid = s_v1;
  assign bus_rr.req1_a     = s_a1;   assign bus_fp.req1_a     = s_a1;
  assign bus_rr.req1_b     = s_b1;   assign bus_fp.req1_b     = s_b1;
  assign bus_rr.req1_op    = s_op1;  assign bus_fp.req1_op    = s_op1;
  assign bus_rr.rsp_ready  = s_rdy;  assign bus_fp.rsp_ready  = s_rdy;

  // Bench ALU: ADD 0x04/0x0B, ADC 0x05, A+4 0x10, A+B+4 0x11, anything else XOR.
  function automatic logic [DW+1:0] alu_f(logic [DW-1:0] a, logic [DW-1:0] b,
                                          logic [OW-1:0] op, logic cin);
    logic [DW:0] s;
    logic v;
    v = 1'b0;
    case (op)
      5'h04, 5'h0B: s = {1'b0, a} + {1'b0, b};
      5'h05:        s = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
      5'h10:        s = {1'b0, a} + 33'd4;
      5'h11:        s = {1'b0, a} + {1'b0, b} + 33'd4;
      default:      s = {1'b0, a ^ b};
    endcase
    if (op == 5'h04 || op == 5'h0B || op == 5'h05)
      v = (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]);
    return {s[DW], v, s[DW-1:0]};
  endfunction

  assign {rr_c, rr_v, rr_out} = alu_f(rr_a, rr_b, rr_op, rr_cin);
  assign {fp_c, fp_v, fp_out} = alu_f(fp_a, fp_b, fp_op, fp_cin);

  alu_issue_arbiter #(.DATA_W(DW), .OP_W(OW), .RR_MODE(1'b1), .STARVE_MAX(STARVE)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(bus_rr.slave),
    .alu_a(rr_a), .alu_b(rr_b), .alu_op(rr_op), .alu_cin(rr_cin),
    .alu_out(rr_out), .alu_c(rr_c), .alu_v(rr_v), .flags_q(rr_flags));

  alu_issue_arbiter #(.DATA_W(DW), .OP_W(OW), .RR_MODE(1'b0), .STARVE_MAX(STARVE)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(bus_fp.slave),
    .alu_a(fp_a), .alu_b(fp_b), .alu_op(fp_op), .alu_cin(fp_cin),
    .alu_out(fp_out), .alu_c(fp_c), .alu_v(fp_v), .flags_q(fp_flags));

  // Reference model: index 0 = round-robin DUT, index 1 = fixed-priority DUT.
  typedef struct {
    bit            valid;
    bit            id;
    logic [DW-1:0] data;
    logic [3:0]    flags;
    int            last;
    int            starve;
  } mstate_t;

  mstate_t m[2];
  logic    obs_r0[2];
  logic    obs_r1[2];

  function automatic void mreset(int k);
    m[k].valid = 0; m[k].id = 0; m[k].data = '0; m[k].flags = 4'b0000;
    m[k].last = 1; m[k].starve = 0;
  endfunction

  // Returns the port that should be granted this cycle, or -1 for none.
  function automatic int mgrant(int k);
    bit can;
    can = !m[k].valid || s_rdy;
    if (!can) return -1;
    if (s_v0 && s_v1) begin
      if (k == 0) return (m[k].last == 0) ? 1 : 0;
      return (m[k].starve == STARVE) ? 1 : 0;
    end
    if (s_v0) return 0;
    if (s_v1) return 1;
    return -1;
  endfunction

  function automatic void mupdate(int k);
    int g;
    bit can;
    logic [DW+1:0] r;
    g   = mgrant(k);
    can = !m[k].valid || s_rdy;
    if (g == 1) m[k].starve = 0;
    else if (s_v1 && can && m[k].starve < STARVE) m[k].starve++;
    if (g >= 0) begin
      r = (g == 1) ? alu_f(s_a1, s_b1, s_op1, m[k].flags[1])
                   : alu_f(s_a0, s_b0, s_op0, m[k].flags[1]);
      m[k].valid = 1;
      m[k].id    = (g == 1);
      m[k].data  = r[DW-1:0];
      m[k].last  = g;
      if (g == 0 && s_setf0)
        m[k].flags = {r[DW-1], (r[DW-1:0] == '0), r[DW+1], r[DW]};
    end else if (can && m[k].valid) begin
      m[k].valid = 0;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkRegs();
    checkOutput("rr rsp_valid", bus_rr.rsp_valid, m[0].valid);
    checkOutput("rr rsp_id",    bus_rr.rsp_id,    m[0].id);
    checkOutput("rr rsp_data",  bus_rr.rsp_data,  m[0].data);
    checkOutput("rr flags",     rr_flags,         m[0].flags);
    checkOutput("fp rsp_valid", bus_fp.rsp_valid, m[1].valid);
    checkOutput("fp rsp_id",    bus_fp.rsp_id,    m[1].id);
    checkOutput("fp rsp_data",  bus_fp.rsp_data,  m[1].data);
    checkOutput("fp flags",     fp_flags,         m[1].flags);
  endtask

  // One clock: inputs are already set at posedge+1; readys are sampled at the falling edge.
  task automatic applyStimulus();
    int g;
    @(negedge clk);
    obs_r0[0] = bus_rr.req0_ready; obs_r1[0] = bus_rr.req1_ready;
    obs_r0[1] = bus_fp.req0_ready; obs_r1[1] = bus_fp.req1_ready;
    for (int k = 0; k < 2; k++) begin
      g = mgrant(k);
      checkOutput($sformatf("dut%0d req0_ready", k), obs_r0[k], g == 0);
      checkOutput($sformatf("dut%0d req1_ready", k), obs_r1[k], g == 1);
    end
    checkOutput("rr alu_cin", rr_cin, m[0].flags[1]);
    checkOutput("fp alu_cin", fp_cin, m[1].flags[1]);
    mupdate(0);
    mupdate(1);
    @(posedge clk);
    #1;
    checkRegs();
  endtask

  task automatic setIdle();
    s_v0 = 0; s_a0 = '0; s_b0 = '0; s_op0 = '0; s_setf0 = 0;
    s_v1 = 0; s_a1 = '0; s_b1 = '0; s_op1 = '0; s_rdy = 1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    setIdle();
    s_v0 = 1; s_v1 = 1;
    #3;
    checkOutput("reset rr req0_ready", bus_rr.req0_ready, 1'b0);
    checkOutput("reset rr req1_ready", bus_rr.req1_ready, 1'b0);
    checkOutput("reset fp req0_ready", bus_fp.req0_ready, 1'b0);
    checkOutput("reset fp req1_ready", bus_fp.req1_ready, 1'b0);
    mreset(0);
    mreset(1);
    checkRegs();
    @(posedge clk);
    #1;
    setIdle();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit v0; logic [DW-1:0] a0, b0; logic [OW-1:0] op0; bit setf;
    bit v1; logic [DW-1:0] a1, b1; logic [OW-1:0] op1;
    bit rdy;
    bit er0, er1, evalid, eid; logic [DW-1:0] edata; logic [3:0] eflags;
  } vec_t;

  vec_t          tbl[12];
  logic [OW-1:0] op_pool[7];

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tbl[0]  = '{1, 5, 7, 5'h04, 1,  0, 0, 0, 5'h10,  1,  1, 0, 1, 0, 32'd12, 4'b0000};
    tbl[1]  = '{1, 1, 2, 5'h04, 0,  1, 32'h100, 0, 5'h10,  1,  0, 1, 1, 1, 32'h104, 4'b0000};
    tbl[2]  = '{1, 1, 2, 5'h04, 0,  1, 32'h100, 0, 5'h10,  1,  1, 0, 1, 0, 32'd3, 4'b0000};
    tbl[3]  = '{1, 1, 2, 5'h04, 0,  1, 32'h100, 0, 5'h10,  1,  0, 1, 1, 1, 32'h104, 4'b0000};
    tbl[4]  = '{1, 1, 2, 5'h04, 0,  1, 32'h100, 0, 5'h10,  0,  0, 0, 1, 1, 32'h104, 4'b0000};
    tbl[5]  = '{0, 0, 0, 5'h04, 0,  0, 0, 0, 5'h10,  1,  0, 0, 0, 1, 32'h104, 4'b0000};
    tbl[6]  = '{0, 0, 0, 5'h04, 0,  0, 0, 0, 5'h10,  0,  0, 0, 0, 1, 32'h104, 4'b0000};
    tbl[7]  = '{1, 32'hFFFFFFFF, 1, 5'h0B, 1,  0, 0, 0, 5'h10,  1,  1, 0, 1, 0, 32'd0, 4'b0110};
    tbl[8]  = '{1, 0, 0, 5'h05, 0,  0, 0, 0, 5'h10,  1,  1, 0, 1, 0, 32'd1, 4'b0110};
    tbl[9]  = '{0, 0, 0, 5'h04, 0,  1, 8, 2, 5'h11,  1,  0, 1, 1, 1, 32'd14, 4'b0110};
    tbl[10] = '{1, 32'h7FFFFFFF, 1, 5'h04, 1,  0, 0, 0, 5'h10,  1,  1, 0, 1, 0, 32'h80000000, 4'b1001};
    tbl[11] = '{1, 32'h80000000, 32'h80000000, 5'h04, 0,  0, 0, 0, 5'h10,  1,  1, 0, 1, 0, 32'd0, 4'b1001};
    op_pool = '{5'h00, 5'h02, 5'h04, 5'h05, 5'h0B, 5'h10, 5'h11};

    doReset();

    // table vectors against the round-robin instance
    for (int i = 0; i < 12; i++) begin
      s_v0 = tbl[i].v0; s_a0 = tbl[i].a0; s_b0 = tbl[i].b0; s_op0 = tbl[i].op0; s_setf0 = tbl[i].setf;
      s_v1 = tbl[i].v1; s_a1 = tbl[i].a1; s_b1 = tbl[i].b1; s_op1 = tbl[i].op1; s_rdy = tbl[i].rdy;
      applyStimulus();
      checkOutput($sformatf("vec%0d ready0", i), obs_r0[0], tbl[i].er0);
      checkOutput($sformatf("vec%0d ready1", i), obs_r1[0], tbl[i].er1);
      checkOutput($sformatf("vec%0d rsp_valid", i), bus_rr.rsp_valid, tbl[i].evalid);
      checkOutput($sformatf("vec%0d rsp_id", i), bus_rr.rsp_id, tbl[i].eid);
      checkOutput($sformatf("vec%0d rsp_data", i), bus_rr.rsp_data, tbl[i].edata);
      checkOutput($sformatf("vec%0d flags", i), rr_flags, tbl[i].eflags);
    end

    // held response: no grants for 3 clocks, then drain and issue on one edge
    s_v0 = 1; s_a0 = 3; s_b0 = 4; s_op0 = 5'h04; s_setf0 = 0;
    s_v1 = 1; s_a1 = 32'h20; s_b1 = 0; s_op1 = 5'h10; s_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("hold rr ready0", obs_r0[0], 1'b0);
      checkOutput("hold rr ready1", obs_r1[0], 1'b0);
      checkOutput("hold rr rsp_data", bus_rr.rsp_data, tbl[11].edata);
    end
    s_rdy = 1;
    applyStimulus();
    checkOutput("drain+issue rr ready1", obs_r1[0], 1'b1);
    checkOutput("drain+issue rr rsp_valid", bus_rr.rsp_valid, 1'b1);
    checkOutput("drain+issue rr rsp_data", bus_rr.rsp_data, 32'h24);

    // asynchronous reset while FULL, away from any clock edge
    s_rdy = 0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst rr rsp_valid", bus_rr.rsp_valid, 1'b0);
    checkOutput("async rst rr flags", rr_flags, 4'b0000);
    checkOutput("async rst fp rsp_valid", bus_fp.rsp_valid, 1'b0);
    checkOutput("async rst rr req0_ready", bus_rr.req0_ready, 1'b0);
    doReset();

    // both always valid: round-robin alternates, fixed priority forces port 1 every 5th
    s_v0 = 1; s_a0 = 32'h11; s_b0 = 32'h22; s_op0 = 5'h04; s_setf0 = 0;
    s_v1 = 1; s_a1 = 32'h400; s_b1 = 0; s_op1 = 5'h10; s_rdy = 1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput($sformatf("pattern fp cycle%0d ready1", i), obs_r1[1], (i % 5) == 4);
      checkOutput($sformatf("pattern rr cycle%0d ready1", i), obs_r1[0], (i % 2) == 1);
      checkOutput($sformatf("pattern rr cycle%0d rsp_valid", i), bus_rr.rsp_valid, 1'b1);
    end

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      s_v0    = ($urandom_range(0, 3) != 0);
      s_a0    = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom();
      s_b0    = ($urandom_range(0, 7) == 0) ? 32'd1 : $urandom();
      s_op0   = op_pool[$urandom_range(0, 6)];
      s_setf0 = $urandom_range(0, 1) == 1;
      s_v1    = ($urandom_range(0, 2) != 0);
      s_a1    = $urandom();
      s_b1    = $urandom();
      s_op1   = ($urandom_range(0, 1) == 1) ? 5'h11 : 5'h10;
      s_rdy   = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
